// File: rtl/raw10_pkg.sv
// Shared types and constants for the MIPI RAW10 unpacker.
// The optional macro RAW10_VC_FILTER_EN (used in the top) enables virtual-channel filtering.
package raw10_pkg;

  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam int         BUF_DEPTH   = 8;
  localparam int         GROUP_BYTES = 5;
  localparam int         GROUP_PIX   = 4;

  typedef logic [9:0] pixel_t;
  typedef logic [7:0] byte_t;

  // Pixel k takes its 8 MSBs from byte k and its 2 LSBs from bits [2k+1:2k] of the packed fifth byte.
  function automatic pixel_t unpack_pixel(input byte_t msb, input byte_t lsbs, input int k);
    return {msb, lsbs[2*k +: 2]};
  endfunction

endpackage

// File: rtl/raw10_group_decode.sv
// Combinational decode of one 5-byte RAW10 group into four 10-bit pixels.
module raw10_group_decode
  import raw10_pkg::*;
(
  input  logic [4:0][7:0] i_bytes,
  output logic [3:0][9:0] o_pixels
);

  always_comb begin
    o_pixels = '0;
    for (int k = 0; k < GROUP_PIX; k++) begin
      o_pixels[k] = unpack_pixel(i_bytes[k], i_bytes[4], k);
    end
  end

endmodule

// File: rtl/raw10_unpacker.sv
// RAW10 unpacker: 4-byte beats in, 4x10-bit pixel groups out, with line tracking.
// Define RAW10_VC_FILTER_EN to accept only beats whose virtual channel equals VC.
module raw10_unpacker
  import raw10_pkg::*;
#(
  parameter logic [1:0] VC = 2'd0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0][7:0] image_data,
  input  logic [7:0]      image_data_type,
  input  logic            image_data_enable,
  input  logic [15:0]     word_count,
  input  logic [1:0]      virtual_channel,
  output logic [3:0][9:0] pixel,
  output logic            pixel_valid,
  output logic            line_done,
  output logic            length_error
);

  logic [7:0][7:0] r_buf_p0;
  logic [3:0]      r_fill_p0;
  logic [15:0]     r_byte_cnt_p0;

  logic [3:0][9:0] r_pixel_p1;
  logic            r_vld_p1;
  logic            r_line_done_p1;
  logic            r_length_error;

  logic            w_vc_ok;
  logic            w_accept;
  logic [7:0][7:0] w_ext;
  logic [7:0][7:0] w_shift;
  logic [3:0]      w_fill_app;
  logic [3:0]      w_fill_post;
  logic            w_emit;
  logic [16:0]     w_cnt_next;
  logic            w_last;
  logic            w_len_bad;
  logic [3:0][9:0] w_pix;

`ifdef RAW10_VC_FILTER_EN
  assign w_vc_ok = (virtual_channel == VC);
`else
  logic w_unused_vc;
  assign w_vc_ok     = 1'b1;
  assign w_unused_vc = ^{virtual_channel, VC};
`endif

  assign w_accept = image_data_enable && w_vc_ok &&
                    (image_data_type == {2'b00, DT_RAW10});

  // Stage p0: append the beat behind the bytes already held; fill is at most 4 here.
  always_comb begin
    w_ext = r_buf_p0;
    for (int i = 0; i < 4; i++) begin
      w_ext[r_fill_p0[2:0] + 3'(i)] = image_data[i];
    end
  end

  assign w_fill_app  = r_fill_p0 + 4'd4;
  assign w_emit      = w_accept && (w_fill_app >= 4'(GROUP_BYTES));
  assign w_fill_post = w_emit ? (w_fill_app - 4'(GROUP_BYTES)) : w_fill_app;
  assign w_shift     = w_emit ? {40'h0, w_ext[7:5]} : w_ext;

  // 17-bit count so that the +4 can never wrap past word_count.
  assign w_cnt_next = {1'b0, r_byte_cnt_p0} + 17'd4;
  assign w_last     = w_accept && (w_cnt_next >= {1'b0, word_count});
  assign w_len_bad  = (w_cnt_next != {1'b0, word_count}) || (w_fill_post != 4'd0);

  raw10_group_decode u_decode (
    .i_bytes  (w_ext[4:0]),
    .o_pixels (w_pix)
  );

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_buf_p0 <= w_shift;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fill_p0     <= 4'd0;
      r_byte_cnt_p0 <= 16'd0;
    end else if (w_accept) begin
      if (w_last) begin
        r_fill_p0     <= 4'd0;
        r_byte_cnt_p0 <= 16'd0;
      end else begin
        r_fill_p0     <= w_fill_post;
        r_byte_cnt_p0 <= w_cnt_next[15:0];
      end
    end
  end

  // Stage p1: registered group output, line pulse and sticky length flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pixel_p1     <= '0;
      r_vld_p1       <= 1'b0;
      r_line_done_p1 <= 1'b0;
      r_length_error <= 1'b0;
    end else begin
      r_vld_p1       <= w_emit;
      r_line_done_p1 <= w_last;
      if (w_emit) begin
        r_pixel_p1 <= w_pix;
      end
      if (w_last && w_len_bad) begin
        r_length_error <= 1'b1;
      end
    end
  end

  assign pixel        = r_pixel_p1;
  assign pixel_valid  = r_vld_p1;
  assign line_done    = r_line_done_p1;
  assign length_error = r_length_error;

endmodule
